// File: rtl/fetch_unit_pkg.sv
// Shared processor constants and types for the fetch stage.
// Decode and the instruction-memory model import the same widths from here.
package fetch_unit_pkg;

  localparam int              ADDR_W   = 16;
  localparam int              INSTR_W  = 16;
  localparam int              OFFSET_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, decode handshake
// and the redirect (taken jump) channel.
interface fetch_unit_if #(
  parameter int ADDR_W   = fetch_unit_pkg::ADDR_W,
  parameter int INSTR_W  = fetch_unit_pkg::INSTR_W,
  parameter int OFFSET_W = fetch_unit_pkg::OFFSET_W
);

  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;

  logic [INSTR_W-1:0]  instr;
  logic [ADDR_W-1:0]   instr_pc;
  logic                instr_valid;
  logic                instr_ready;

  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;
  logic [OFFSET_W-1:0] redirect_offset;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc, redirect_offset
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc, redirect_offset
  );

endinterface

// File: rtl/fetch_target_add.sv
// Combinational address adder: base + sign-extended 8-bit offset, wrapping
// modulo 2^ADDR_W. Serves both PC+1 and redirect target computation.
module fetch_target_add #(
  parameter int ADDR_W   = fetch_unit_pkg::ADDR_W,
  parameter int OFFSET_W = fetch_unit_pkg::OFFSET_W
) (
  input  logic [ADDR_W-1:0]   base,
  input  logic [OFFSET_W-1:0] offset,
  output logic [ADDR_W-1:0]   sum
);

  logic [ADDR_W-1:0] offset_ext;

  // Sign-extend the offset and add; the carry out is dropped so the sum wraps.
  always_comb begin
    offset_ext = {{(ADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    sum        = base + offset_ext;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, a
// single-entry instruction holding register towards decode, and redirect
// handling that drains an in-flight request before issuing the target.
module fetch_unit #(
  parameter int                ADDR_W   = fetch_unit_pkg::ADDR_W,
  parameter int                INSTR_W  = fetch_unit_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = fetch_unit_pkg::RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  fetch_unit_if.master bus
);

  import fetch_unit_pkg::*;

  fetch_state_e          state, state_d;
  logic [ADDR_W-1:0]     pc, pc_d;
  logic [ADDR_W-1:0]     req_addr, req_addr_d;
  logic [INSTR_W-1:0]    instr_q;
  logic [ADDR_W-1:0]     instr_pc_q;
  logic                  instr_valid_q;

  logic [ADDR_W-1:0]     add_base, add_sum;
  logic [OFFSET_W-1:0]   add_off;

  logic                  redirect_en;
  logic                  capture;
  logic                  release_instr;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design updates from the same pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned, which would infer a latch.
    state_d = state;
    case (state)
      ST_IDLE:  if (start) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.redirect)      state_d = bus.imem_ack ? ST_REQ : ST_DRAIN;
        else if (bus.imem_ack) state_d = ST_HOLD;
      end
      ST_HOLD:  if (bus.redirect || (instr_valid_q && bus.instr_ready)) state_d = ST_REQ;
      ST_DRAIN: if (bus.imem_ack) state_d = ST_REQ;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs and datapath strobes.
  always_comb begin
    bus.imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
    busy          = (state != ST_IDLE);
    redirect_en   = bus.redirect && (state != ST_IDLE);
    capture       = (state == ST_REQ) && bus.imem_ack && !bus.redirect;
    release_instr = (state == ST_HOLD) && (bus.redirect || (instr_valid_q && bus.instr_ready));
  end

  // Shared adder operand select: redirect target wins, otherwise PC+1.
  always_comb begin
    add_base = pc;
    add_off  = OFFSET_W'(1);
    if (redirect_en) begin
      add_base = bus.redirect_pc;
      add_off  = bus.redirect_offset;
    end
  end

  fetch_target_add #(
    .ADDR_W   (ADDR_W),
    .OFFSET_W (OFFSET_W)
  ) u_target_add (
    .base   (add_base),
    .offset (add_off),
    .sum    (add_sum)
  );

  // Next PC and request address. The request address is frozen while a
  // redirected request drains so the memory sees a stable address; otherwise
  // it follows the PC so REQ always issues the current PC.
  always_comb begin
    pc_d = pc;
    if (redirect_en || capture) pc_d = add_sum;
    req_addr_d = (state_d == ST_DRAIN) ? req_addr : pc_d;
  end

  // PC, request address and the instruction holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      req_addr      <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      pc       <= pc_d;
      req_addr <= req_addr_d;
      if (capture) begin
        instr_q       <= bus.imem_rdata;
        instr_pc_q    <= pc;
        instr_valid_q <= 1'b1;
      end else if (release_instr) begin
        instr_valid_q <= 1'b0;
      end
    end
  end

  // Registered values onto the bus.
  always_comb begin
    bus.imem_addr   = req_addr;
    bus.instr       = instr_q;
    bus.instr_pc    = instr_pc_q;
    bus.instr_valid = instr_valid_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a behavioural model
// that tracks "requesting / holding an instruction / draining" as flags.
module tb_fetch_unit;

  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus modes: ack 0=never 1=whenever requested 2=random 3=always;
  // ready 0=low 1=high 2=random.
  int ack_mode   = 0;
  int ready_mode = 0;

  // Behavioural model.
  logic        m_busy;
  logic        m_have;
  logic        m_drain;
  logic [15:0] m_pc;
  logic [15:0] m_drain_addr;
  logic [15:0] m_instr;
  logic [15:0] m_instr_pc;

  function automatic logic m_req();
    return m_busy && !m_have;
  endfunction

  function automatic logic [15:0] m_addr();
    return m_drain ? m_drain_addr : m_pc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_step();
    int          t;
    logic [15:0] tgt;
    logic [16:0] inc;
    t   = int'(bus.redirect_pc) + int'($signed(bus.redirect_offset));
    tgt = t[15:0];
    inc = {1'b0, m_pc} + 17'd1;
    if (reset) begin
      m_busy     = 1'b0;
      m_have     = 1'b0;
      m_drain    = 1'b0;
      m_pc       = RESET_PC;
      m_instr    = '0;
      m_instr_pc = '0;
    end else if (!m_busy) begin
      if (start) m_busy = 1'b1;
    end else if (m_have) begin
      if (bus.redirect) begin
        m_pc   = tgt;
        m_have = 1'b0;
      end else if (bus.instr_ready) begin
        m_have = 1'b0;
      end
    end else if (m_drain) begin
      if (bus.imem_ack) m_drain = 1'b0;
      if (bus.redirect) m_pc = tgt;
    end else begin
      if (bus.redirect) begin
        if (!bus.imem_ack) begin
          m_drain      = 1'b1;
          m_drain_addr = m_pc;
        end
        m_pc = tgt;
      end else if (bus.imem_ack) begin
        m_have     = 1'b1;
        m_instr    = bus.imem_rdata;
        m_instr_pc = m_pc;
        m_pc       = inc[15:0];
      end
    end
  endtask

  task automatic drive_auto();
    case (ack_mode)
      0:       bus.imem_ack = 1'b0;
      1:       bus.imem_ack = m_req();
      2:       bus.imem_ack = 1'($urandom_range(0, 1));
      default: bus.imem_ack = 1'b1;
    endcase
    bus.imem_rdata = 16'($urandom);
    case (ready_mode)
      0:       bus.instr_ready = 1'b0;
      1:       bus.instr_ready = 1'b1;
      default: bus.instr_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: update model on the edge, compare on the falling edge, then
  // drive the automatic part of the next cycle's stimulus.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("imem_req",    bus.imem_req,    m_req());
    check("imem_addr",   bus.imem_addr,   m_addr());
    check("instr_valid", bus.instr_valid, m_have);
    check("busy",        busy,            m_busy);
    check("instr",       bus.instr,       m_instr);
    check("instr_pc",    bus.instr_pc,    m_instr_pc);
    drive_auto();
  endtask

  logic [15:0] addr_q[$];
  logic [15:0] ipc_q[$];
  logic [5:0]  valid_bits;
  logic [15:0] held;
  logic        found;

  initial begin
    reset               = 1'b1;
    start               = 1'b0;
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = '0;
    bus.instr_ready     = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_pc     = '0;
    bus.redirect_offset = '0;
    m_busy = 1'b0; m_have = 1'b0; m_drain = 1'b0;
    m_pc = RESET_PC; m_drain_addr = RESET_PC; m_instr = '0; m_instr_pc = '0;

    // Reset state.
    tick();
    tick();
    check("rst_addr",  bus.imem_addr,   RESET_PC);
    check("rst_req",   bus.imem_req,    1'b0);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_busy",  busy,            1'b0);

    // Zero-wait streaming: addresses 0,1,2 with a valid every second cycle.
    reset = 1'b0; start = 1'b1; ack_mode = 1; ready_mode = 1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.imem_req)    addr_q.push_back(bus.imem_addr);
      if (bus.instr_valid) ipc_q.push_back(bus.instr_pc);
      valid_bits[i] = bus.instr_valid;
    end
    check("stream_nreq",  addr_q.size(), 3);
    check("stream_nval",  ipc_q.size(),  3);
    check("stream_valid", valid_bits,    6'b101010);
    for (int i = 0; i < 3; i++) begin
      if (i < addr_q.size()) check("stream_addr", addr_q[i], i);
      if (i < ipc_q.size())  check("stream_ipc",  ipc_q[i],  i);
    end

    // Stall decode with the instruction fetched from PC 5.
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (m_req() && m_addr() == 16'd5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reach_pc5", found, 1'b1);
    ready_mode = 0; bus.instr_ready = 1'b0;
    tick();
    check("stall_ipc0", bus.instr_pc, 16'd5);
    held = bus.instr;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_instr", bus.instr,       held);
      check("stall_ipc",   bus.instr_pc,    16'd5);
      check("stall_req",   bus.imem_req,    1'b0);
      check("stall_valid", bus.instr_valid, 1'b1);
    end
    ready_mode = 1; bus.instr_ready = 1'b1;
    tick();
    check("stall_rel_valid", bus.instr_valid, 1'b0);
    check("stall_rel_addr",  bus.imem_addr,   16'd6);

    // Redirect in HOLD with a negative offset, racing a ready handshake.
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0010; bus.redirect_offset = 8'hFC;
    tick();
    bus.redirect = 1'b0;
    check("hold_redir_addr",  bus.imem_addr,   16'h000C);
    check("hold_redir_req",   bus.imem_req,    1'b1);
    check("hold_redir_valid", bus.instr_valid, 1'b0);

    // Redirect while a request is pending; ack arrives three cycles late.
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0020; bus.redirect_offset = 8'h00;
    ack_mode = 0; bus.imem_ack = 1'b0;
    tick();
    check("pend_addr", bus.imem_addr, 16'h0020);
    bus.redirect_offset = 8'h10;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain_addr",  bus.imem_addr,   16'h0020);
      check("drain_req",   bus.imem_req,    1'b1);
      check("drain_valid", bus.instr_valid, 1'b0);
      if (i == 2) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hBEEF;
      end else begin
        tick();
      end
    end
    tick();
    check("post_drain_addr",  bus.imem_addr,   16'h0030);
    check("post_drain_valid", bus.instr_valid, 1'b0);
    ack_mode = 1; bus.imem_ack = 1'b1;
    tick();
    check("post_drain_ipc", bus.instr_pc, 16'h0030);

    // PC wrap at 16'hFFFF and a positive-offset target wrap.
    bus.redirect = 1'b1; bus.redirect_pc = 16'hFFF0; bus.redirect_offset = 8'h0F;
    tick();
    bus.redirect = 1'b0;
    check("wrap_addr_ffff", bus.imem_addr, 16'hFFFF);
    tick();
    check("wrap_ipc_ffff", bus.instr_pc, 16'hFFFF);
    tick();
    check("wrap_addr_0000", bus.imem_addr, 16'h0000);
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 16'hFFF0; bus.redirect_offset = 8'h7F;
    tick();
    bus.redirect = 1'b0;
    check("target_7f", bus.imem_addr, 16'h006F);

    // Reset during a pending request, then a late ack in IDLE.
    ack_mode = 0; bus.imem_ack = 1'b0;
    tick();
    check("pre_rst_req", bus.imem_req, 1'b1);
    reset = 1'b1;
    tick();
    check("mid_rst_busy", busy,          1'b0);
    check("mid_rst_addr", bus.imem_addr, RESET_PC);
    reset = 1'b0; start = 1'b0; ack_mode = 3; bus.imem_ack = 1'b1;
    tick();
    tick();
    check("late_ack_valid", bus.instr_valid, 1'b0);
    check("late_ack_req",   bus.imem_req,    1'b0);
    check("late_ack_addr",  bus.imem_addr,   RESET_PC);

    // Randomized traffic against the model.
    ack_mode = 2; ready_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      reset               = ($urandom_range(0, 99) == 0);
      start               = ($urandom_range(0, 3) != 0);
      bus.redirect        = ($urandom_range(0, 4) == 0);
      bus.redirect_pc     = 16'($urandom);
      bus.redirect_offset = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
